// File: rtl/sync_filter_n.sv
// Multi-channel input conditioner: N-stage synchroniser, stability filter and
// registered rise/fall edge detector, all in the CLK domain.
module sync_filter_n #(
    parameter int unsigned      WIDTH       = 2,
    parameter int unsigned      STAGES      = 2,
    parameter int unsigned      FILT_CYCLES = 4,
    parameter logic [WIDTH-1:0] RESET_VAL   = '0
) (
    input  logic             CLK,
    input  logic             ACLR_L,
    input  logic [WIDTH-1:0] ASYNC,
    output logic [WIDTH-1:0] SYNC,
    output logic [WIDTH-1:0] FILT,
    output logic [WIDTH-1:0] RISE,
    output logic [WIDTH-1:0] FALL
);

    localparam int unsigned     CntW   = (FILT_CYCLES > 1) ? $clog2(FILT_CYCLES) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(FILT_CYCLES - 1);

    logic [WIDTH-1:0] sync_q [STAGES];
    logic [WIDTH-1:0] filt_q, filt_d;
    logic [WIDTH-1:0] rise_q, rise_d;
    logic [WIDTH-1:0] fall_q, fall_d;
    logic [CntW-1:0]  cnt_q  [WIDTH];
    logic [CntW-1:0]  cnt_d  [WIDTH];

    // Pure flop chain: nothing may sit between stages.
    always_ff @(posedge CLK or negedge ACLR_L) begin
        if (!ACLR_L) begin
            for (int s = 0; s < int'(STAGES); s++) begin
                sync_q[s] <= RESET_VAL;
            end
        end else begin
            sync_q[0] <= ASYNC;
            for (int s = 1; s < int'(STAGES); s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    assign SYNC = sync_q[STAGES-1];

    // Count consecutive edges of disagreement; accept SYNC once it has held
    // for FILT_CYCLES edges. Accepting a change is the only source of pulses.
    always_comb begin
        filt_d = filt_q;
        rise_d = '0;
        fall_d = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            cnt_d[i] = '0;
            if (SYNC[i] != filt_q[i]) begin
                if (cnt_q[i] == CntMax) begin
                    filt_d[i] = SYNC[i];
                    rise_d[i] = SYNC[i];
                    fall_d[i] = ~SYNC[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge ACLR_L) begin
        if (!ACLR_L) begin
            filt_q <= RESET_VAL;
            rise_q <= '0;
            fall_q <= '0;
            for (int i = 0; i < int'(WIDTH); i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            filt_q <= filt_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
            for (int i = 0; i < int'(WIDTH); i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign FILT = filt_q;
    assign RISE = rise_q;
    assign FALL = fall_q;

endmodule

// File: tb/tb_sync_filter_n.sv
// Directed bench for sync_filter_n with WIDTH=2, STAGES=2, FILT_CYCLES=4.
module tb_sync_filter_n;

    logic       CLK;
    logic       ACLR_L;
    logic [1:0] ASYNC;
    logic [1:0] SYNC, FILT, RISE, FALL;

    int n_checks = 0;
    int n_pass   = 0;

    sync_filter_n #(
        .WIDTH      (2),
        .STAGES     (2),
        .FILT_CYCLES(4),
        .RESET_VAL  (2'b00)
    ) dut (
        .CLK   (CLK),
        .ACLR_L(ACLR_L),
        .ASYNC (ASYNC),
        .SYNC  (SYNC),
        .FILT  (FILT),
        .RISE  (RISE),
        .FALL  (FALL)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    endtask

    task automatic check_all(input string scen, input int k, input logic [1:0] es,
                             input logic [1:0] ef, input logic [1:0] er, input logic [1:0] el);
        check($sformatf("%s k=%0d SYNC", scen, k), SYNC, es);
        check($sformatf("%s k=%0d FILT", scen, k), FILT, ef);
        check($sformatf("%s k=%0d RISE", scen, k), RISE, er);
        check($sformatf("%s k=%0d FALL", scen, k), FALL, el);
    endtask

    // Reset with idle inputs, then let everything settle at 00.
    task automatic reset_idle();
        ACLR_L = 1'b0;
        ASYNC  = 2'b00;
        repeat (3) tick();
        ACLR_L = 1'b1;
        repeat (8) tick();
    endtask

    initial begin
        ACLR_L = 1'b0;
        ASYNC  = 2'b11;

        // Reset held with inputs high: everything cleared.
        #2;
        check_all("rst_hold", 0, 2'b00, 2'b00, 2'b00, 2'b00);
        repeat (3) tick();
        check_all("rst_hold", 3, 2'b00, 2'b00, 2'b00, 2'b00);

        // Release with ASYNC=11: SYNC after edge 2, FILT and RISE after edge 6.
        ACLR_L = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            tick();
            check_all("release", k, (k >= 2) ? 2'b11 : 2'b00, (k >= 6) ? 2'b11 : 2'b00,
                      (k == 6) ? 2'b11 : 2'b00, 2'b00);
        end

        // 3-cycle glitch on channel 0 is rejected.
        reset_idle();
        ASYNC = 2'b01;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (k == 3) ASYNC = 2'b00;
            check_all("glitch", k, (k >= 2 && k <= 4) ? 2'b01 : 2'b00, 2'b00, 2'b00, 2'b00);
        end

        // 4-cycle pulse is the shortest accepted: FILT high edges 6..9.
        ASYNC = 2'b01;
        for (int k = 1; k <= 14; k++) begin
            tick();
            if (k == 4) ASYNC = 2'b00;
            check_all("minpulse", k, (k >= 2 && k <= 5) ? 2'b01 : 2'b00,
                      (k >= 6 && k <= 9) ? 2'b01 : 2'b00,
                      (k == 6) ? 2'b01 : 2'b00, (k == 10) ? 2'b01 : 2'b00);
        end

        // Bounce 1,1,0,1,1...: the 0 restarts the count, FILT rises at edge 9.
        ASYNC = 2'b01;
        for (int k = 1; k <= 14; k++) begin
            tick();
            ASYNC = (k == 2) ? 2'b00 : 2'b01;
            check_all("bounce", k, (k == 2 || k == 3 || k >= 5) ? 2'b01 : 2'b00,
                      (k >= 9) ? 2'b01 : 2'b00, (k == 9) ? 2'b01 : 2'b00, 2'b00);
        end

        // Mid-operation reset while channel 0 count is 2 (FILT=01, SYNC=00).
        ASYNC = 2'b00;
        for (int k = 1; k <= 4; k++) begin
            tick();
            check_all("pre_rst", k, (k >= 2) ? 2'b00 : 2'b01, 2'b01, 2'b00, 2'b00);
        end
        ACLR_L = 1'b0;
        #1;
        check_all("mid_rst", 0, 2'b00, 2'b00, 2'b00, 2'b00);
        repeat (2) tick();
        ACLR_L = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            check_all("post_rst", k, 2'b00, 2'b00, 2'b00, 2'b00);
        end

        // Settle FILT=10, then swap to 01: RISE=01 and FALL=10 together at edge 6.
        ASYNC = 2'b10;
        repeat (8) tick();
        check_all("settle", 8, 2'b10, 2'b10, 2'b00, 2'b00);
        ASYNC = 2'b01;
        for (int k = 1; k <= 10; k++) begin
            tick();
            check_all("swap", k, (k >= 2) ? 2'b01 : 2'b10, (k >= 6) ? 2'b01 : 2'b10,
                      (k == 6) ? 2'b01 : 2'b00, (k == 6) ? 2'b10 : 2'b00);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
